// File: rtl/agc_timing_pkg.sv
// Shared timing definitions for the time-pulse generator: pulse count,
// sequencer states and the one-hot T01..T12 encodings.
package agc_timing_pkg;

  localparam int NTP = 12;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    STEP = 2'd2
  } tp_state_e;

  localparam logic [NTP-1:0] TP_T01 = 12'h001;
  localparam logic [NTP-1:0] TP_T02 = 12'h002;
  localparam logic [NTP-1:0] TP_T03 = 12'h004;
  localparam logic [NTP-1:0] TP_T04 = 12'h008;
  localparam logic [NTP-1:0] TP_T05 = 12'h010;
  localparam logic [NTP-1:0] TP_T06 = 12'h020;
  localparam logic [NTP-1:0] TP_T07 = 12'h040;
  localparam logic [NTP-1:0] TP_T08 = 12'h080;
  localparam logic [NTP-1:0] TP_T09 = 12'h100;
  localparam logic [NTP-1:0] TP_T10 = 12'h200;
  localparam logic [NTP-1:0] TP_T11 = 12'h400;
  localparam logic [NTP-1:0] TP_T12 = 12'h800;

  // T12 wraps back to T01.
  function automatic logic [NTP-1:0] tp_rotate(input logic [NTP-1:0] tp_in);
    return {tp_in[NTP-2:0], tp_in[NTP-1]};
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Modulo-PHASES counter with enable, synchronous clear (priority over enable)
// and a terminal-count flag that is high while the count sits at PHASES-1.
module phase_counter #(
  parameter int PHASES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       clr,
  output logic [$clog2(PHASES)-1:0]  count,
  output logic                       tc
);

  localparam int PW = $clog2(PHASES);

  logic [PW-1:0] count_d;
  logic [PW-1:0] count_q;

  assign tc    = (count_q == PW'(PHASES - 1));
  assign count = count_q;

  // Next count: clear, wrap at terminal count, or increment.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      if (tc) begin
        count_d = '0;
      end else begin
        count_d = count_q + PW'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/timepulse_gen.sv
// Memory-cycle-time sequencer: steps one-hot pulses T01..T12, each PHASES
// clocks long, with stop-at-MCT-boundary and single-MCT step control.
module timepulse_gen
  import agc_timing_pkg::*;
#(
  parameter int PHASES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stop_req,
  input  logic                       step,
  output logic [NTP-1:0]             tp,
  output logic [$clog2(PHASES)-1:0]  phase,
  output logic                       mct_end,
  output logic                       running,
  output logic                       halted
);

  tp_state_e      state_d, state_q;
  logic [NTP-1:0] tp_d, tp_q;
  logic           stop_pending_d, stop_pending_q;
  logic           cnt_en, cnt_clr, cnt_tc;

  assign cnt_en  = (state_q != HALT);
  assign cnt_clr = (state_q == HALT);

  phase_counter #(.PHASES(PHASES)) u_phase_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .count (phase),
    .tc    (cnt_tc)
  );

  assign tp      = tp_q;
  assign mct_end = tp_q[NTP-1] & cnt_tc;
  assign running = |tp_q;
  assign halted  = (state_q == HALT);

  // Sequencer: pulse rotation, MCT-boundary halting and HALT exits.
  always_comb begin
    state_d        = state_q;
    tp_d           = tp_q;
    stop_pending_d = stop_pending_q;
    case (state_q)
      RUN: begin
        stop_pending_d = stop_pending_q | stop_req;
        if (mct_end) begin
          if (stop_pending_q | stop_req) begin
            state_d        = HALT;
            tp_d           = '0;
            stop_pending_d = 1'b0;
          end else begin
            state_d = RUN;
            tp_d    = TP_T01;
          end
        end else if (cnt_tc) begin
          tp_d = tp_rotate(tp_q);
        end else begin
          tp_d = tp_q;
        end
      end
      STEP: begin
        // Only the stop_req level at the final cycle decides where STEP goes.
        if (mct_end) begin
          if (stop_req) begin
            state_d        = HALT;
            tp_d           = '0;
            stop_pending_d = 1'b0;
          end else begin
            state_d = RUN;
            tp_d    = TP_T01;
          end
        end else if (cnt_tc) begin
          tp_d = tp_rotate(tp_q);
        end else begin
          tp_d = tp_q;
        end
      end
      HALT: begin
        stop_pending_d = 1'b0;
        if (!stop_req) begin
          state_d = RUN;
          tp_d    = TP_T01;
        end else if (step) begin
          state_d = STEP;
          tp_d    = TP_T01;
        end else begin
          state_d = HALT;
          tp_d    = '0;
        end
      end
      default: begin
        state_d        = RUN;
        tp_d           = TP_T01;
        stop_pending_d = 1'b0;
      end
    endcase
  end

  // State, pulse and stop-request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= RUN;
      tp_q           <= TP_T01;
      stop_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      tp_q           <= tp_d;
      stop_pending_q <= stop_pending_d;
    end
  end

endmodule

// File: tb/tb_timepulse_gen.sv
// Bench for timepulse_gen at PHASES = 4, 2 and 16 sharing one stimulus stream,
// each checked against a position-in-MCT reference model.
module tb_timepulse_gen;

  logic clk = 1'b0;
  logic rst, stop_req, step;

  logic [11:0] tp4, tp2, tp16;
  logic [1:0]  ph4;
  logic [0:0]  ph2;
  logic [3:0]  ph16;
  logic        me4, me2, me16, run4, run2, run16, h4, h2, h16;

  timepulse_gen #(.PHASES(4)) dut4 (.clk(clk), .rst(rst), .stop_req(stop_req), .step(step),
    .tp(tp4), .phase(ph4), .mct_end(me4), .running(run4), .halted(h4));
  timepulse_gen #(.PHASES(2)) dut2 (.clk(clk), .rst(rst), .stop_req(stop_req), .step(step),
    .tp(tp2), .phase(ph2), .mct_end(me2), .running(run2), .halted(h2));
  timepulse_gen #(.PHASES(16)) dut16 (.clk(clk), .rst(rst), .stop_req(stop_req), .step(step),
    .tp(tp16), .phase(ph16), .mct_end(me16), .running(run16), .halted(h16));

  always #5 clk = ~clk;

  logic [18:0] obs [3];
  assign obs[0] = {tp4,  4'(ph4),  me4,  run4,  h4};
  assign obs[1] = {tp2,  4'(ph2),  me2,  run2,  h2};
  assign obs[2] = {tp16, 4'(ph16), me16, run16, h16};

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode plus position within the MCT, per instance.
  localparam int M_RUN = 0, M_HALT = 1, M_STEP = 2;
  int P [3] = '{4, 2, 16};
  int pos [3];
  int mode [3];
  bit pend [3];

  function automatic logic [18:0] exp_vec(int i);
    logic [11:0] t;
    logic [3:0]  ph;
    logic        e;
    if (mode[i] == M_HALT) return {12'h000, 4'h0, 1'b0, 1'b0, 1'b1};
    t  = 12'h001;
    t  = t << (pos[i] / P[i]);
    ph = 4'(pos[i] % P[i]);
    e  = (pos[i] == 12 * P[i] - 1);
    return {t, ph, e, 1'b1, 1'b0};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      pos[i] = 0; mode[i] = M_RUN; pend[i] = 1'b0;
    end
  endtask

  task automatic model_advance();
    bit at_end, halt_now;
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        pos[i] = 0; mode[i] = M_RUN; pend[i] = 1'b0;
      end else if (mode[i] == M_HALT) begin
        if (!stop_req) begin mode[i] = M_RUN; pos[i] = 0; end
        else if (step) begin mode[i] = M_STEP; pos[i] = 0; end
      end else begin
        at_end = (pos[i] == 12 * P[i] - 1);
        if (mode[i] == M_RUN) begin
          halt_now = pend[i] | stop_req;
          pend[i]  = pend[i] | stop_req;
        end else begin
          halt_now = stop_req;
        end
        if (at_end) begin
          if (halt_now) begin mode[i] = M_HALT; pend[i] = 1'b0; end
          else begin mode[i] = M_RUN; pos[i] = 0; end
        end else begin
          pos[i] = pos[i] + 1;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; stop_req = 1'b0; step = 1'b0;
    model_reset();
    #1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs[k] !== exp_vec(k)) begin
          n_bad++;
          $display("FAIL reset P=%0d: got %h expected %h", P[k], obs[k], exp_vec(k));
        end
      end
      n_cmp++;
      if (tp4 !== 12'h001 || ph4 !== 2'd0 || h4 !== 1'b0 || run4 !== 1'b1 || me4 !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_values: got tp=%h ph=%0d h=%b r=%b me=%b expected tp=001 ph=0 h=0 r=1 me=0",
                 tp4, ph4, h4, run4, me4);
      end
    end
  endtask

  task automatic test_free_run();
    logic [11:0] one, t_exp;
    do_reset();
    one = 12'h001;
    for (int c = 0; c < 200; c++) begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs[k] !== exp_vec(k)) begin
          n_bad++;
          $display("FAIL free_run P=%0d cyc %0d: got %h expected %h", P[k], c, obs[k], exp_vec(k));
        end
      end
      t_exp = one << ((c % 48) / 4);
      n_cmp++;
      if (tp4 !== t_exp || me4 !== (c % 48 == 47) || !$onehot(tp4)) begin
        n_bad++;
        $display("FAIL free_run_p4 cyc %0d: got tp=%h me=%b expected tp=%h me=%b",
                 c, tp4, me4, t_exp, (c % 48 == 47));
      end
      n_cmp++;
      if (me2 !== (c % 24 == 23) || me16 !== (c % 192 == 191)) begin
        n_bad++;
        $display("FAIL free_run_mct_len cyc %0d: got me2=%b me16=%b expected %b %b",
                 c, me2, me16, (c % 24 == 23), (c % 192 == 191));
      end
      cyc();
    end
  endtask

  task automatic test_stop();
    do_reset();
    for (int c = 0; c < 200; c++) begin
      stop_req = (c == 10) || (c >= 48);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs[k] !== exp_vec(k)) begin
          n_bad++;
          $display("FAIL stop P=%0d cyc %0d: got %h expected %h", P[k], c, obs[k], exp_vec(k));
        end
      end
      if (c == 47 || c >= 48) begin
        n_cmp++;
        if ((c == 47 && me4 !== 1'b1) || (c >= 48 && (h4 !== 1'b1 || tp4 !== 12'h000))) begin
          n_bad++;
          $display("FAIL stop_halt_p4 cyc %0d: got me=%b h=%b tp=%h", c, me4, h4, tp4);
        end
      end
      cyc();
    end
  endtask

  task automatic test_step();
    int runs [3];
    runs = '{0, 0, 0};
    stop_req = 1'b1;
    for (int c = 0; c < 250; c++) begin
      step = (c == 0) || (c == 10);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs[k] !== exp_vec(k)) begin
          n_bad++;
          $display("FAIL step P=%0d cyc %0d: got %h expected %h", P[k], c, obs[k], exp_vec(k));
        end
      end
      runs[0] += int'(run4); runs[1] += int'(run2); runs[2] += int'(run16);
      cyc();
    end
    step = 1'b0;
    n_cmp++;
    if (runs[0] != 48 || runs[1] != 24 || runs[2] != 192) begin
      n_bad++;
      $display("FAIL step_length: got %0d/%0d/%0d expected 48/24/192", runs[0], runs[1], runs[2]);
    end
  endtask

  task automatic test_step_run();
    stop_req = 1'b0; step = 1'b1;
    cyc();
    step = 1'b0;
    for (int c = 0; c < 60; c++) begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs[k] !== exp_vec(k)) begin
          n_bad++;
          $display("FAIL step_run P=%0d cyc %0d: got %h expected %h", P[k], c, obs[k], exp_vec(k));
        end
      end
      n_cmp++;
      if (h4 !== 1'b0 || (c == 48 && tp4 !== 12'h001)) begin
        n_bad++;
        $display("FAIL step_run_p4 cyc %0d: got h=%b tp=%h", c, h4, tp4);
      end
      cyc();
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    while (!(mode[0] == M_RUN && pos[0] == 25) && guard < 200) begin
      cyc();
      guard++;
    end
    n_cmp++;
    if (guard >= 200) begin
      n_bad++;
      $display("FAIL async_wait: got timeout expected T07 within 200 cycles");
    end
    #2 rst = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (tp4 !== 12'h001 || ph4 !== 2'd0 || tp16 !== 12'h001 || ph16 !== 4'd0) begin
      n_bad++;
      $display("FAIL async_reset: got tp=%h ph=%0d expected tp=001 ph=0", tp4, ph4);
    end
    @(negedge clk);
    model_reset();
    rst = 1'b1;
    for (int c = 0; c < 60; c++) begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs[k] !== exp_vec(k)) begin
          n_bad++;
          $display("FAIL async_after P=%0d cyc %0d: got %h expected %h", P[k], c, obs[k], exp_vec(k));
        end
      end
      if (c == 1) begin
        n_cmp++;
        if (ph4 !== 2'd1) begin
          n_bad++;
          $display("FAIL first_edge_phase: got %0d expected 1", ph4);
        end
      end
      cyc();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 29) == 0) stop_req = ~stop_req;
      step = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs[k] !== exp_vec(k) || (obs[k][18:7] !== 12'h000 && !$onehot(obs[k][18:7]))) begin
          n_bad++;
          $display("FAIL random P=%0d cyc %0d: got %h expected %h", P[k], c, obs[k], exp_vec(k));
        end
      end
      cyc();
    end
    step = 1'b0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stop();
    test_step();
    test_step_run();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timepulse_gen.md
TIMEPULSE_GEN -- requirements
Module: timepulse_gen

Interface
REQ-001 SHALL have parameter PHASES, default 4: clock cycles per time pulse; legal range 2..16.
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port stop_req, input, 1 bit: level request to halt at the next memory-cycle-time (MCT) boundary.
REQ-005 SHALL have port step, input, 1 bit: single-cycle pulse requesting exactly one MCT while halted.
REQ-006 SHALL have port tp, output, 12 bits: time pulses T01..T12, one-hot, bit 0 = T01; these drive downstream gate-level logic.
REQ-007 SHALL have port phase, output, clog2(PHASES) bits: index of the current clock cycle within the active time pulse.
REQ-008 SHALL have port mct_end, output, 1 bit: high for exactly the last cycle of T12.
REQ-009 SHALL have port running, output, 1 bit: high whenever tp is non-zero.
REQ-010 SHALL have port halted, output, 1 bit: high in the HALT state only.

Function
REQ-011 SHALL use three states: RUN, HALT and STEP; STEP sequences pulses identically to RUN.
REQ-012 In RUN or STEP, phase SHALL count 0..PHASES-1 and wrap to 0.
REQ-013 On each phase wrap, tp SHALL rotate left one position, so T12 is followed by T01.
REQ-014 One MCT SHALL last exactly 12*PHASES cycles (48 at the default PHASES).
REQ-015 mct_end SHALL be asserted combinationally when tp[11]=1 and phase=PHASES-1.
REQ-016 A stop_pending flag SHALL set in any RUN cycle in which stop_req=1; it SHALL clear on entry to HALT.
REQ-017 In RUN, a cycle with mct_end=1 and stop_pending (or stop_req) set SHALL be followed by HALT; otherwise RUN continues at T01.
REQ-018 In HALT:
- tp SHALL be all-zero, phase 0, mct_end 0.
- running SHALL be 0 and halted SHALL be 1.
REQ-019 From HALT with stop_req=0, the next cycle SHALL be RUN with tp=T01 and phase=0.
REQ-020 From HALT with stop_req=1 and step=1, the next cycle SHALL be STEP with tp=T01 and phase=0.
REQ-021 When HALT sees both stop_req=0 and step=1, the RUN transition SHALL win and step SHALL be discarded.
REQ-022 At mct_end in STEP:
- next state SHALL be HALT if stop_req=1, otherwise RUN at T01;
- stop_req SHALL be sampled in that cycle only.
REQ-023 step SHALL be ignored in RUN and STEP and SHALL NOT be queued.
REQ-024 tp SHALL never have more than one bit set.
REQ-025 tp and phase SHALL be registered outputs with no combinational path from any input.

Reset
REQ-026 While rst=0, outputs SHALL be: tp=T01 (12'h001), phase=0, state RUN, stop_pending=0, mct_end=0, running=1, halted=0.
REQ-027 Assertion of rst SHALL take effect immediately, regardless of clk, including mid-MCT or in HALT/STEP.
REQ-028 On the first rising clk edge after rst deasserts, phase SHALL advance to 1.

Structure
REQ-029 Shared package agc_timing_pkg SHALL hold:
- NTP=12;
- the state enum {RUN, HALT, STEP};
- named one-hot constants TP_T01..TP_T12.
REQ-030 Sub-module phase_counter SHALL provide:
- a modulo-PHASES counter with enable, synchronous clear and terminal-count output;
- the same clk/rst ports.
timepulse_gen SHALL instantiate it once.

Verification
REQ-031 Reset then free-run 100 cycles, PHASES=4 -> tp T01 for cycles 0-3, T02 for 4-7, ...; mct_end at cycles 47 and 95; one-hot every cycle.
REQ-032 stop_req pulsed high one cycle at cycle 10 -> mct_end at 47, halted=1 and tp=0 from cycle 48 on.
REQ-033 Halted, stop_req=1, step pulse -> exactly 48 cycles of T01..T12, then HALT again; a second step during the MCT is ignored.
REQ-034 Halted, stop_req dropped in the same cycle as step -> RUN at T01 next cycle and continues past T12.
REQ-035 rst asserted asynchronously mid-T07 -> tp=12'h001 and phase=0 before the next clk edge; normal sequence after release.
REQ-036 PHASES=2 and PHASES=16 -> MCT lengths of 24 and 192 cycles; phase wraps at 1 and 15 respectively.
